fetch_decode_queue: RTL and testbench
=====================================

// Module: fetch_decode_queue
// PURPOSE
//  Instruction FIFO between the fetch stage and the decode stage.
//  - Captures each fetched instruction word together with its PC.
//  - Decouples decode stalls from fetch. Decode stalls back-pressure the PC via queue_full.
//  - Absorbs the NOP bubbles fetch emits while an I-cache miss is being served.
//  - Provides a one-cycle flush on taken branches so wrong-path instructions are discarded.
// PARAMETERS
//  WORD_WIDTH  16  instruction word width
//  ADDR_WIDTH  16  PC width
//  DEPTH       4   number of entries; must be a power of two
//  PTR_BITS    2   log2(DEPTH)
// PORTS
//  clk          in   1              rising-edge clock
//  reset        in   1              reset, synchronous, active-low
//  push_valid   in   1              fetch presents a real (non-bubble) instruction this cycle
//  push_inst    in   WORD_WIDTH     instruction word from fetch
//  push_pc      in   ADDR_WIDTH     PC of push_inst
//  queue_full   out  1              count==DEPTH; fetch deasserts enable_pc while high
//  flush        in   1              taken branch / redirect; discard all entries
//  pop_ready    in   1              decode accepts the head entry this cycle
//  out_valid    out  1              head entry valid (count!=0)
//  out_inst     out  WORD_WIDTH     head instruction; 16'h0000 (NOP) when empty
//  out_pc       out  ADDR_WIDTH     head PC; 0 when empty
//  count        out  PTR_BITS+1     number of occupied entries, 0..DEPTH
//  push_drop    out  1              registered 1-cycle pulse: a push was rejected
// BEHAVIOUR
//  - Reset: reset==0 sampled at posedge clears wr_ptr, rd_ptr, count, push_drop.
//    Resulting outputs: out_valid=0, out_inst=0, out_pc=0, queue_full=0.
//    Storage contents need not be cleared. Reset overrides flush, push and pop.
//  - Show-ahead (first-word-fall-through) FIFO.
//    out_valid, out_inst and out_pc are combinational from the head entry and count.
//    When count==0: out_inst=16'h0000 and out_pc=0, regardless of storage contents.
//  - pop   = out_valid & pop_ready.
//  - push  = push_valid & (!queue_full | pop).
//    A push into a full queue is accepted only if a pop occurs in the same cycle.
//  - A rejected push (push_valid & !push) sets push_drop=1 for the next cycle.
//    A rejected push is an upstream protocol error.
//  - Latency: a pushed word is visible on out_* one cycle later. There is no same-cycle bypass.
//  - Pointers advance modulo DEPTH; wrap from DEPTH-1 to 0 is silent.
//  - count update: count_next = count + push - pop, never outside 0..DEPTH.
//  - Simultaneous push and pop: count unchanged, both pointers advance.
//    This holds when full and when count==1.
//  - flush==1 (reset inactive) has priority over push and pop:
//    next cycle count=0, wr_ptr=rd_ptr=0.
//    A same-cycle push is discarded; push_drop is not raised for it.
//    pop_ready is ignored.
//  - Flush and reset have no state machine beyond the pointers.
//  - Flush while empty: no effect other than pointer realignment.
//  - queue_full = (count==DEPTH) is combinational.
//    Fetch sees it in the same cycle and must hold the PC.
// TESTING
//  1 Reset: hold reset=0 for 2 clks with push_valid=1
//    -> count=0, out_valid=0, out_inst=16'h0000, queue_full=0.
//  2 Fill: pop_ready=0, push 0x1111..0x4444 at PCs 0x10..0x13
//    -> count=4, queue_full=1, out_inst=0x1111, out_pc=0x10.
//    A fifth push gives push_drop=1 one cycle later and count stays 4.
//  3 Full push+pop: from scenario 2, push 0x5555 with pop_ready=1
//    -> count=4, out_inst=0x2222.
//    Draining then yields 0x2222, 0x3333, 0x4444, 0x5555 in order (pointer wrap exercised).
//  4 Flush priority: count=3, assert flush with push_valid=1 and pop_ready=1
//    -> next cycle count=0, out_valid=0, push_drop=0.
//    The next push 0xAAAA appears at the head one cycle later.
//  5 Miss bubbles: alternate push_valid 1/0 with 0xB001, 0xB002 and pop_ready=1
//    -> decode sees only 0xB001 and 0xB002, each one cycle after its push.
//    out_valid=0 in the gaps.
//  6 Reset mid-operation: count=2, drive reset=0 for one clk alongside a push and a flush
//    -> count=0 next cycle. Queue resumes normally after reset=1.

Source files
------------

// File: rtl/fetch_decode_queue.sv
// Show-ahead instruction FIFO between fetch and decode: holds {inst, pc} pairs,
// back-pressures fetch via queue_full and discards wrong-path entries on flush.
module fetch_decode_queue #(
   parameter int WORD_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int DEPTH      = 4,
   parameter int PTR_BITS   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push_valid,
   input  logic [WORD_WIDTH-1:0] push_inst,
   input  logic [ADDR_WIDTH-1:0] push_pc,
   output logic                  queue_full,
   input  logic                  flush,
   input  logic                  pop_ready,
   output logic                  out_valid,
   output logic [WORD_WIDTH-1:0] out_inst,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [PTR_BITS:0]     count,
   output logic                  push_drop
);

   localparam logic [PTR_BITS:0] FULL_CNT = DEPTH[PTR_BITS:0];

   logic [WORD_WIDTH-1:0] inst_mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];

   logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_BITS:0]   count_q, count_d;
   logic                drop_q, drop_d;
   logic                push, pop;

   assign queue_full = (count_q == FULL_CNT);
   assign out_valid  = (count_q != '0);
   assign pop        = out_valid & pop_ready;
   assign push       = push_valid & (~queue_full | pop);

   // Head is forced to NOP/0 when empty so stale storage never leaks to decode.
   assign out_inst  = out_valid ? inst_mem_q[rd_ptr_q] : '0;
   assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]   : '0;
   assign count     = count_q;
   assign push_drop = drop_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop_d   = 1'b0;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + {{PTR_BITS{1'b0}}, push} - {{PTR_BITS{1'b0}}, pop};
         drop_d  = push_valid & ~push;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
      end
   end

   // Storage carries no reset; it is only ever read through a valid head.
   always_ff @(posedge clk) begin
      if (reset && !flush && push) begin
         inst_mem_q[wr_ptr_q] <= push_inst;
         pc_mem_q[wr_ptr_q]   <= push_pc;
      end
   end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: hand-derived vector table for the directed
// scenarios, then random traffic against a queue-based reference model.
module tb_fetch_decode_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        push_valid = 1'b0;
   logic [15:0] push_inst = '0;
   logic [15:0] push_pc = '0;
   logic        queue_full;
   logic        flush = 1'b0;
   logic        pop_ready = 1'b0;
   logic        out_valid;
   logic [15:0] out_inst;
   logic [15:0] out_pc;
   logic [2:0]  count;
   logic        push_drop;

   int vectors = 0;
   int miscompares = 0;

   fetch_decode_queue #(
      .WORD_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(DEPTH), .PTR_BITS(2)
   ) dut (
      .clk(clk), .reset(reset), .push_valid(push_valid), .push_inst(push_inst),
      .push_pc(push_pc), .queue_full(queue_full), .flush(flush),
      .pop_ready(pop_ready), .out_valid(out_valid), .out_inst(out_inst),
      .out_pc(out_pc), .count(count), .push_drop(push_drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        pv;
      logic [15:0] inst;
      logic [15:0] pc;
      logic        fl;
      logic        pr;
      logic [2:0]  cnt;
      logic        ov;
      logic [15:0] oi;
      logic [15:0] opc;
      logic        full;
      logic        drop;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst_n, input logic pv, input logic [15:0] inst,
                      input logic [15:0] pc, input logic fl, input logic pr,
                      input logic [2:0] cnt, input logic ov, input logic [15:0] oi,
                      input logic [15:0] opc, input logic full, input logic drop);
      vec_t v;
      v.rst_n = rst_n; v.pv = pv; v.inst = inst; v.pc = pc; v.fl = fl; v.pr = pr;
      v.cnt = cnt; v.ov = ov; v.oi = oi; v.opc = opc; v.full = full; v.drop = drop;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic rst_n, input logic pv, input logic [15:0] inst,
                        input logic [15:0] pc, input logic fl, input logic pr);
      reset = rst_n; push_valid = pv; push_inst = inst; push_pc = pc;
      flush = fl; pop_ready = pr;
   endtask

   task automatic compare(input string name, input logic [37:0] exp);
      logic [37:0] act;
      act = {count, out_valid, out_inst, out_pc, queue_full, push_drop};
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got cnt=%0d vld=%b inst=%h pc=%h full=%b drop=%b, want cnt=%0d vld=%b inst=%h pc=%h full=%b drop=%b",
                  name, act[37:35], act[34], act[33:18], act[17:2], act[1], act[0],
                  exp[37:35], exp[34], exp[33:18], exp[17:2], exp[1], exp[0]);
      end
   endtask

   // Reference model: a plain queue of {inst, pc} plus the drop flag.
   logic [31:0] model_q[$];
   logic        model_drop = 1'b0;

   task automatic model_step(input logic rst_n, input logic pv, input logic [15:0] inst,
                             input logic [15:0] pc, input logic fl, input logic pr);
      bit do_pop, do_push;
      if (!rst_n || fl) begin
         model_q.delete();
         model_drop = 1'b0;
      end else begin
         do_pop  = (model_q.size() != 0) && pr;
         do_push = pv && ((model_q.size() < DEPTH) || do_pop);
         model_drop = pv && !do_push;
         if (do_pop) void'(model_q.pop_front());
         if (do_push) model_q.push_back({inst, pc});
      end
   endtask

   function automatic logic [37:0] model_out();
      logic [31:0] head;
      logic [2:0]  n;
      head = (model_q.size() != 0) ? model_q[0] : 32'h0;
      n = 3'(model_q.size());
      return {n, (model_q.size() != 0), head[31:16], head[15:0],
              (model_q.size() == DEPTH), model_drop};
   endfunction

   initial begin
      // rst_n pv inst pc fl pr | cnt ov oi opc full drop
      add(0,1,16'h1234,16'h0099,0,0, 0,0,16'h0000,16'h0000,0,0);  // reset held
      add(0,1,16'h1234,16'h0099,0,0, 0,0,16'h0000,16'h0000,0,0);
      add(1,1,16'h1111,16'h0010,0,0, 1,1,16'h1111,16'h0010,0,0);  // fill
      add(1,1,16'h2222,16'h0011,0,0, 2,1,16'h1111,16'h0010,0,0);
      add(1,1,16'h3333,16'h0012,0,0, 3,1,16'h1111,16'h0010,0,0);
      add(1,1,16'h4444,16'h0013,0,0, 4,1,16'h1111,16'h0010,1,0);
      add(1,1,16'h9999,16'h0014,0,0, 4,1,16'h1111,16'h0010,1,1);  // rejected push
      add(1,1,16'h5555,16'h0015,0,1, 4,1,16'h2222,16'h0011,1,0);  // full push+pop
      add(1,0,16'h0000,16'h0000,0,1, 3,1,16'h3333,16'h0012,0,0);  // drain, wrap
      add(1,0,16'h0000,16'h0000,0,1, 2,1,16'h4444,16'h0013,0,0);
      add(1,0,16'h0000,16'h0000,0,1, 1,1,16'h5555,16'h0015,0,0);
      add(1,0,16'h0000,16'h0000,0,1, 0,0,16'h0000,16'h0000,0,0);
      add(1,1,16'hA001,16'h0020,0,0, 1,1,16'hA001,16'h0020,0,0);
      add(1,1,16'hA002,16'h0021,0,0, 2,1,16'hA001,16'h0020,0,0);
      add(1,1,16'hA003,16'h0022,0,0, 3,1,16'hA001,16'h0020,0,0);
      add(1,1,16'h7777,16'h0023,1,1, 0,0,16'h0000,16'h0000,0,0);  // flush priority
      add(1,1,16'hAAAA,16'h0030,0,0, 1,1,16'hAAAA,16'h0030,0,0);
      add(1,1,16'hBBBB,16'h0031,0,1, 1,1,16'hBBBB,16'h0031,0,0);  // count==1 push+pop
      add(1,0,16'h0000,16'h0000,0,1, 0,0,16'h0000,16'h0000,0,0);
      add(1,1,16'hB001,16'h0040,0,1, 1,1,16'hB001,16'h0040,0,0);  // miss bubbles
      add(1,0,16'h0000,16'h0000,0,1, 0,0,16'h0000,16'h0000,0,0);
      add(1,1,16'hB002,16'h0041,0,1, 1,1,16'hB002,16'h0041,0,0);
      add(1,0,16'h0000,16'h0000,0,1, 0,0,16'h0000,16'h0000,0,0);
      add(1,1,16'hC001,16'h0050,0,0, 1,1,16'hC001,16'h0050,0,0);
      add(1,1,16'hC002,16'h0051,0,0, 2,1,16'hC001,16'h0050,0,0);
      add(0,1,16'hC003,16'h0052,1,0, 0,0,16'h0000,16'h0000,0,0);  // reset mid-op
      add(1,1,16'hC004,16'h0053,0,0, 1,1,16'hC004,16'h0053,0,0);
      add(1,1,16'hC005,16'h0054,0,1, 1,1,16'hC005,16'h0054,0,0);
      add(1,0,16'h0000,16'h0000,1,0, 0,0,16'h0000,16'h0000,0,0);  // flush drops last

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i].rst_n, tbl[i].pv, tbl[i].inst, tbl[i].pc, tbl[i].fl, tbl[i].pr);
         @(posedge clk);
         #1;
         compare($sformatf("vec%0d", i),
                 {tbl[i].cnt, tbl[i].ov, tbl[i].oi, tbl[i].opc, tbl[i].full, tbl[i].drop});
      end

      // Flush while full with a push pending: drop must stay low.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         drive(1, 1, 16'hD000 + 16'(k), 16'h0060 + 16'(k), 0, 0);
         @(posedge clk);
      end
      @(negedge clk);
      drive(1, 1, 16'hDEAD, 16'h00FF, 1, 0);
      @(posedge clk);
      #1;
      compare("flush_full", {3'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0});

      // Random traffic; model starts from the empty state left above.
      model_q.delete();
      model_drop = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         logic        r, pv, fl, pr;
         logic [15:0] inst, pc;
         r    = ($urandom_range(0, 63) != 0);
         pv   = ($urandom_range(0, 9) < 7);
         fl   = ($urandom_range(0, 19) == 0);
         pr   = ($urandom_range(0, 1) == 1);
         inst = 16'($urandom);
         pc   = 16'($urandom);
         @(negedge clk);
         drive(r, pv, inst, pc, fl, pr);
         model_step(r, pv, inst, pc, fl, pr);
         @(posedge clk);
         #1;
         compare($sformatf("rand%0d", n), model_out());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
